// File: rtl/rf_writeback_queue_if.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue_if
// Purpose : bundles the two producer handshakes (memory/load path and ALU
//           path) together with the register-file write port driven by
//           rf_writeback_queue.
// Signals :
//   mem_valid/mem_ready/mem_rd/mem_data  memory/load writeback handshake
//   alu_valid/alu_ready/alu_rd/alu_data  ALU writeback handshake
//   wEn/addrD/dataD                      register-file write port
// Modports:
//   slave  - the queue's view (accepts writebacks, drives the write port)
//   master - the producers'/register file's view
// ---------------------------------------------------------------------------
interface rf_writeback_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          wEn;
    logic [AW-1:0] addrD;
    logic [DW-1:0] dataD;

    modport slave (
        input  mem_valid, mem_rd, mem_data,
        input  alu_valid, alu_rd, alu_data,
        output mem_ready, alu_ready,
        output wEn, addrD, dataD
    );

    modport master (
        output mem_valid, mem_rd, mem_data,
        output alu_valid, alu_rd, alu_data,
        input  mem_ready, alu_ready,
        input  wEn, addrD, dataD
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue
// Purpose : in-order writeback queue in front of the 32x32 register file.
//           Accepts up to two writebacks per cycle (mem entry first, it is
//           the older instruction), drains one per cycle onto the registered
//           write port, and reports pending writes to decode.
// Ports   :
//   clk, reset        clock; synchronous active-low reset
//   bus (slave)       producer handshakes + register-file write port
//   chk_a, chk_b      source register addresses being decoded
//   hazard_a/b        a write to chk_x is still pending
//   fwd_a/b_valid     forwarded data for chk_x is valid
//   fwd_a/b_data      forwarded data for chk_x
//   count, full, empty  queue occupancy
// Build option:
//   RF_WB_FORWARD_EN  when defined, pending writes are forwarded to decode
//                     (youngest match wins) and the matching hazard is
//                     suppressed; otherwise forwarding outputs are tied to 0.
// ---------------------------------------------------------------------------
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    rf_writeback_queue_if.slave    bus,
    input  logic [AW-1:0]          chk_a,
    input  logic [AW-1:0]          chk_b,
    output logic                   hazard_a,
    output logic                   hazard_b,
    output logic                   fwd_a_valid,
    output logic [DW-1:0]          fwd_a_data,
    output logic                   fwd_b_valid,
    output logic [DW-1:0]          fwd_b_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage (no reset needed: occupancy is tracked by r_count)
    logic [AW-1:0] r_rd   [DEPTH];
    logic [DW-1:0] r_data [DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_wen;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dat;

    logic [CW-1:0] w_free;
    logic          w_mem_ready;
    logic          w_alu_ready;
    logic          w_mem_push;
    logic          w_alu_push;
    logic          w_pop;
    logic [PW-1:0] w_alu_slot;
    logic [CW-1:0] w_count_next;

    // Space is judged on the count at the start of the cycle; a pop in the
    // same cycle does not free a slot for this cycle's producers.
    assign w_free      = CW'(DEPTH) - r_count;
    assign w_mem_ready = (w_free != '0);
    // The ALU writeback is younger, so it only gets the last free slot when
    // the memory path is not competing for it.
    assign w_alu_ready = (w_free >= CW'(2)) || ((w_free != '0) && !bus.mem_valid);

    // Writes to x0 complete the handshake but never occupy a slot.
    assign w_mem_push = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);
    assign w_alu_push = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
    assign w_pop      = (r_count != '0);

    // ALU entry lands behind the mem entry when both are pushed together.
    assign w_alu_slot   = r_wr_ptr + PW'(w_mem_push);
    assign w_count_next = r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_rd[r_wr_ptr]   <= bus.mem_rd;
            r_data[r_wr_ptr] <= bus.mem_data;
        end
        if (w_alu_push) begin
            r_rd[w_alu_slot]   <= bus.alu_rd;
            r_data[w_alu_slot] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_dat    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_mem_push) + PW'(w_alu_push);
            r_count  <= w_count_next;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_wen    <= 1'b1;
                r_addr   <= r_rd[r_rd_ptr];
                r_dat    <= r_data[r_rd_ptr];
            end else begin
                r_wen    <= 1'b0;
            end
        end
    end

    // Per-entry occupancy and address match: an entry is live when its age
    // (distance from the read pointer) is below the current count.
    logic [DEPTH-1:0] w_match_a;
    logic [DEPTH-1:0] w_match_b;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PW-1:0] w_age;
            logic          w_occ;
            assign w_age          = PW'(gi) - r_rd_ptr;
            assign w_occ          = (CW'(w_age) < r_count);
            assign w_match_a[gi]  = w_occ && (r_rd[gi] == chk_a);
            assign w_match_b[gi]  = w_occ && (r_rd[gi] == chk_b);
        end
    endgenerate

    // The output stage still counts as pending: the register file only
    // commits it on the falling edge of the cycle it is presented.
    logic w_hit_a;
    logic w_hit_b;
    assign w_hit_a = (chk_a != '0) && ((|w_match_a) || (r_wen && (r_addr == chk_a)));
    assign w_hit_b = (chk_b != '0) && ((|w_match_b) || (r_wen && (r_addr == chk_b)));

`ifdef RF_WB_FORWARD_EN
    logic [PW-1:0] v_idx;

    // Lowest priority first (output stage), then queue entries oldest to
    // youngest, so the youngest matching write overrides everything else.
    always_comb begin
        fwd_a_data = '0;
        fwd_b_data = '0;
        v_idx      = '0;
        if (r_wen && (r_addr == chk_a)) fwd_a_data = r_dat;
        if (r_wen && (r_addr == chk_b)) fwd_b_data = r_dat;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_rd_ptr + PW'(k);
            if (CW'(k) < r_count) begin
                if (r_rd[v_idx] == chk_a) fwd_a_data = r_data[v_idx];
                if (r_rd[v_idx] == chk_b) fwd_b_data = r_data[v_idx];
            end
        end
    end

    assign fwd_a_valid = w_hit_a;
    assign fwd_b_valid = w_hit_b;
    // A forwarded operand never stalls decode.
    assign hazard_a    = w_hit_a && !fwd_a_valid;
    assign hazard_b    = w_hit_b && !fwd_b_valid;
`else
    assign fwd_a_valid = 1'b0;
    assign fwd_b_valid = 1'b0;
    assign fwd_a_data  = '0;
    assign fwd_b_data  = '0;
    assign hazard_a    = w_hit_a;
    assign hazard_b    = w_hit_b;
`endif

    assign bus.mem_ready = w_mem_ready;
    assign bus.alu_ready = w_alu_ready;
    assign bus.wEn       = r_wen;
    assign bus.addrD     = r_addr;
    assign bus.dataD     = r_dat;

    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
endmodule

// File: tb/tb_rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_queue
// Directed scenarios followed by randomized traffic; every cycle the DUT is
// compared against a transaction-level model (a queue of pending writes plus
// the expected register-file write port).
// ---------------------------------------------------------------------------
module tb_rf_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] chk_a, chk_b;
    logic          hazard_a, hazard_b;
    logic          fwd_a_valid, fwd_b_valid;
    logic [DW-1:0] fwd_a_data, fwd_b_data;
    logic [2:0]    count;
    logic          full, empty;

    always #5 clk = ~clk;

    rf_writeback_queue_if #(.AW(AW), .DW(DW)) bus ();

    rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .chk_a       (chk_a),
        .chk_b       (chk_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .fwd_a_valid (fwd_a_valid),
        .fwd_a_data  (fwd_a_data),
        .fwd_b_valid (fwd_b_valid),
        .fwd_b_data  (fwd_b_data),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            total = 0;
    int            bad   = 0;
    bit            acc_m, acc_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pending-write lookup over the model: youngest queued entry first,
    // then older ones, then the write currently on the port.
    task automatic lookup(input logic [AW-1:0] chk, output bit hit, output logic [DW-1:0] d);
        hit = 0;
        d   = '0;
        if (chk != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!hit && q[i].rd == chk) begin
                    hit = 1;
                    d   = q[i].d;
                end
            end
            if (!hit && m_wen && m_addr == chk) begin
                hit = 1;
                d   = m_data;
            end
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model,
    // then check the registered write port after the edge.
    task automatic cycle(input bit rstn,
                         input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic [AW-1:0] ca, input logic [AW-1:0] cb);
        int            free;
        bit            exp_mr, exp_ar, hit_a, hit_b;
        logic [DW-1:0] d_a, d_b;
        reset         = rstn;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        chk_a         = ca;
        chk_b         = cb;
        #1;
        free   = DEPTH - q.size();
        exp_mr = (free >= 1);
        exp_ar = (free >= 2) || (free >= 1 && !mv);
        check("mem_ready", 32'(bus.mem_ready), 32'(exp_mr));
        check("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
        check("count", 32'(count), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
        lookup(ca, hit_a, d_a);
        lookup(cb, hit_b, d_b);
`ifdef RF_WB_FORWARD_EN
        check("fwd_a_valid", 32'(fwd_a_valid), 32'(hit_a));
        check("fwd_b_valid", 32'(fwd_b_valid), 32'(hit_b));
        check("fwd_a_data", fwd_a_data, d_a);
        check("fwd_b_data", fwd_b_data, d_b);
        check("hazard_a", 32'(hazard_a), 32'd0);
        check("hazard_b", 32'(hazard_b), 32'd0);
`else
        check("fwd_a_valid", 32'(fwd_a_valid), 32'd0);
        check("fwd_a_data", fwd_a_data, 32'd0);
        check("hazard_a", 32'(hazard_a), 32'(hit_a));
        check("hazard_b", 32'(hazard_b), 32'(hit_b));
`endif
        acc_m = rstn && mv && exp_mr;
        acc_a = rstn && av && exp_ar;
        if (!rstn) begin
            q.delete();
            m_wen  = 0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (q.size() > 0) begin
                m_wen  = 1;
                m_addr = q[0].rd;
                m_data = q[0].d;
                q.pop_front();
                $display("wb rd=%0d data=%h", m_addr, m_data);
            end else begin
                m_wen = 0;
            end
            if (acc_m && mrd != 0) q.push_back('{rd: mrd, d: md});
            if (acc_a && ard != 0) q.push_back('{rd: ard, d: ad});
        end
        @(posedge clk);
        #1;
        check("wEn", 32'(bus.wEn), 32'(m_wen));
        check("addrD", 32'(bus.addrD), 32'(m_addr));
        check("dataD", bus.dataD, m_data);
    endtask

    task automatic idle(input int n, input logic [AW-1:0] ca);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, ca, 0);
    endtask

    initial begin
        bit            pm_v, pa_v;
        logic [AW-1:0] pm_rd, pa_rd;
        logic [DW-1:0] pm_d, pa_d;

        // First edge establishes a known state before any comparison.
        reset = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        chk_a = 0; chk_b = 0;
        m_wen = 0; m_addr = 0; m_data = 0;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single ALU write
        cycle(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        idle(2, 0);

        // Dual push with one free slot: fill to 3, then both valid
        cycle(1, 1, 1, 32'h101, 1, 2, 32'h102, 0, 0);
        cycle(1, 1, 3, 32'h103, 1, 4, 32'h104, 0, 0);
        cycle(1, 1, 8, 32'h108, 1, 9, 32'h109, 0, 0);
        cycle(1, 0, 0, 0, 1, 9, 32'h109, 0, 0);
        idle(5, 0);

        // Back-to-back ALU writes wrap the pointers
        for (int i = 1; i <= 10; i++) cycle(1, 0, 0, 0, 1, AW'(i), DW'(i * 32'h11), 0, 0);
        idle(2, 0);

        // x0 writes from one and both sources
        cycle(1, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 32'h5678, 1, 0, 32'h9abc, 0, 0);
        idle(1, 0);

        // Hazard / forwarding on a duplicated destination
        cycle(1, 0, 0, 0, 1, 7, 32'hA, 7, 0);
        cycle(1, 0, 0, 0, 1, 7, 32'hB, 7, 7);
        idle(4, 7);

        // Reset with three writes queued
        cycle(1, 1, 11, 32'h11, 1, 12, 32'h12, 11, 12);
        cycle(1, 1, 13, 32'h13, 1, 14, 32'h14, 13, 14);
        cycle(0, 0, 0, 0, 0, 0, 0, 13, 14);
        idle(3, 13);

        // Randomized traffic; producers hold their request until accepted
        pm_v = 0; pa_v = 0; pm_rd = 0; pa_rd = 0; pm_d = 0; pa_d = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pm_v && ($urandom_range(0, 1) == 1)) begin
                pm_v = 1; pm_rd = AW'($urandom_range(0, 7)); pm_d = $urandom;
            end
            if (!pa_v && ($urandom_range(0, 1) == 1)) begin
                pa_v = 1; pa_rd = AW'($urandom_range(0, 7)); pa_d = $urandom;
            end
            cycle(1, pm_v, pm_rd, pm_d, pa_v, pa_rd, pa_d,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            if (acc_m) pm_v = 0;
            if (acc_a) pa_v = 0;
        end
        idle(6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side initiator for the 32x32 register file.
- Accepts register writebacks from two producers, the single-cycle ALU path and the multi-cycle memory/load path, over valid/ready handshakes.
- Buffers them in a small in-order FIFO and drives the register file's single write port (wEn/addrD/dataD) one write per cycle.
- Tells decode which source registers still have writes pending, so decode can stall or forward.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
mem_valid  in  1  memory/load path has a writeback
mem_ready  out  1  queue accepts the mem writeback this cycle
mem_rd  in  AW  destination register
mem_data  in  DW  write data
alu_valid  in  1  ALU path has a writeback
alu_ready  out  1  queue accepts the ALU writeback this cycle
alu_rd  in  AW  destination register
alu_data  in  DW  write data
wEn  out  1  register file write enable, registered
addrD  out  AW  register file write address, registered
dataD  out  DW  register file write data, registered
chk_a  in  AW  rs1 address being decoded
chk_b  in  AW  rs2 address being decoded
hazard_a  out  1  a write to chk_a is still pending
hazard_b  out  1  a write to chk_b is still pending
fwd_a_valid  out  1  forwarded data for chk_a is valid
fwd_a_data  out  DW  forwarded data for chk_a
fwd_b_valid  out  1  forwarded data for chk_b is valid
fwd_b_data  out  DW  forwarded data for chk_b
count  out  clog2(DEPTH)+1  number of occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (reset==0 at a rising edge):
  - count, rd_ptr and wr_ptr go to 0.
  - wEn, addrD and dataD go to 0.
  - All queued entries are discarded, including a reset arriving mid-stream. No write is issued in the following cycle.
- Free-slot count and ready signals:
  - free = DEPTH - count, using count at the start of the cycle. A pop in the same cycle does not add space.
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) || (free >= 1 && !mem_valid).
  - Both readys are combinational and never depend on their own valid.
- Handshake: a transfer occurs when valid && ready are both high at the rising edge. Producers hold valid, rd and data stable until the transfer.
- Enqueue order in one cycle:
  - The mem entry is written before the ALU entry, because the mem instruction is older.
  - Zero, one or two entries are enqueued per cycle.
- Writes to x0: rd == 0 completes the handshake but is not enqueued and consumes no slot. This holds for either source and for both sources at once.
- Drain:
  - Each cycle with count > 0 at the start of the cycle, the head entry is popped.
  - At that edge wEn<=1 and addrD/dataD<=head; otherwise wEn<=0 and addrD/dataD hold their values.
  - At most one pop per cycle. A simultaneous push and pop gives count' = count + pushes - 1.
- Latency:
  - An accepted write into an empty queue at edge N appears on wEn at edge N+1.
  - The register file commits it on the falling edge inside cycle N+1.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.
- Hazard detection (combinational):
  - hazard_a = (chk_a != 0) && (chk_a matches any occupied entry, or wEn && addrD == chk_a).
  - The output stage counts because its value is not readable until after the falling edge.
  - hazard_b is defined the same way on chk_b.
- Ordering: duplicate rd values in the queue are allowed and drain in order; the last write wins in the register file.

Optional Feature:
Macro: RF_WB_FORWARD_EN
- Defined:
  - fwd_x_valid = 1 when hazard conditions match.
  - fwd_x_data = data of the youngest matching entry. Priority is youngest queue entry, then older entries, then the output stage.
  - hazard_x is forced to 0 whenever fwd_x_valid = 1, so decode uses the forwarded data and does not stall.
- Not defined:
  - fwd_a_valid, fwd_b_valid, fwd_a_data and fwd_b_data are tied to 0.
  - hazard_x behaves as in Behaviour.

Test Plan:
- Single write: reset low 2 cycles, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1; next cycle wEn=1, addrD=5, dataD=0xDEADBEEF; the cycle after, wEn=0, empty=1.
- Dual push with one free slot: prefill to count=3 with no drain possible, then mem_valid=alu_valid=1 -> mem_ready=1, alu_ready=0; mem entry enqueued; ALU entry accepted on a later cycle; drain order is mem then ALU.
- Fill and wrap: 10 back-to-back ALU writes rd=1..10, data=rd*0x11 -> wEn pulses 10 consecutive cycles with exactly these addr/data in order; count stays ≤4; full never set, since pop equals push rate.
- x0 discard: mem_rd=0, data=0x1234 with valid -> handshake completes, count unchanged, no wEn pulse, hazard_a=0 for chk_a=0.
- Hazard and forwarding: queue rd=7 data=0xA then rd=7 data=0xB, set chk_a=7 -> without macro, hazard_a=1 until the cycle after the second write's wEn; with RF_WB_FORWARD_EN, fwd_a_valid=1, fwd_a_data=0xB, hazard_a=0.
- Reset mid-operation: count=3, assert reset=0 for 1 edge -> count=0, wEn=0 next cycle, no queued write ever reaches addrD.
